rcv_control_fsm: RTL and testbench
==================================

// Module: rcv_control_fsm
// PURPOSE
// - Receiver control unit for the USB receiver datapath; sits directly downstream of the bit timer.
// - Consumes the timer's shift_enable/byte_received strobes, the decoded byte, the EOP flag and the
//   edge strobe. Frames each packet: detects start, checks the SYNC byte, and writes data bytes into
//   the RX FIFO. Flags framing, sync and overrun errors.
// - Drives rcving back into the timer and the write strobe into the FIFO.
// PARAMETERS
// - SYNC_BYTE   8'h80  value rcv_data must equal on the first received byte of a packet
// - BITS_PER_B  8      shift_enable strobes per byte (internal bit counter width = $clog2(BITS_PER_B)+1)
// PORTS
// - clk            in   1  system clock, all state on rising edge
// - rst            in   1  synchronous, active-high reset
// - d_edge         in   1  1-cycle strobe: edge detected on decoded line
// - eop            in   1  level: end-of-packet (SE0) currently on bus
// - shift_enable   in   1  1-cycle strobe from timer: bit sampled this cycle
// - byte_received  in   1  1-cycle strobe from timer: full byte shifted in
// - rcv_data       in   8  assembled byte; valid while byte_received=1 and held >=BITS_PER_B cycles
// - rx_full        in   1  RX FIFO full
// - rcving         out  1  packet in progress (timer count enable / clear)
// - w_enable       out  1  1-cycle FIFO write strobe, data = rcv_data latched at byte_received
// - rx_data        out  8  byte presented with w_enable
// - r_error        out  1  sticky error flag for current/last packet
// BEHAVIOUR
// - Reset (rst=1 at clk edge): state=IDLE, rcving=0, w_enable=0, rx_data=0, r_error=0, bit_cnt=0.
//   rst overrides every other input, including mid-packet; no FIFO write occurs on reset cycle.
// - Registered Moore outputs except w_enable (registered pulse, exactly 1 cycle wide).
// - bit_cnt: +1 on shift_enable while rcving=1; cleared on byte_received, in IDLE and in EIDLE.
//   If shift_enable and byte_received coincide, clear wins.
// - States / transitions (evaluated each clk):
//   IDLE      : d_edge -> START (r_error cleared, rcving=1 from next cycle).
//   START     : byte_received -> CHK_SYNC, byte latched; eop -> EIDLE (r_error=1).
//   CHK_SYNC  : 1 cycle. latched==SYNC_BYTE -> RECEIVE; else -> NOMATCH (r_error=1).
//   NOMATCH   : wait; eop -> EOP_WAIT_ERR.
//   RECEIVE   : byte_received & !rx_full -> STORE; byte_received & rx_full -> NOMATCH (overrun,
//               r_error=1, byte dropped); eop & shift_enable & bit_cnt==0 -> EOP_WAIT;
//               eop & shift_enable & bit_cnt!=0 -> EOP_WAIT_ERR (r_error=1, partial byte dropped).
//   STORE     : w_enable=1, rx_data=latched byte for this one cycle -> RECEIVE.
//   EOP_WAIT  : rcving=0; d_edge (EOP end) -> IDLE.
//   EOP_WAIT_ERR: rcving=0; d_edge -> EIDLE.
//   EIDLE     : r_error held 1; d_edge -> START (r_error cleared same transition).
// - rcving=1 in START, CHK_SYNC, NOMATCH, RECEIVE, STORE; 0 elsewhere.
// - Latency: byte_received in RECEIVE -> w_enable asserted 2 cycles later (RECEIVE->STORE edge,
//   output registered). Max one write per byte; never two consecutive w_enable cycles.
// - Simultaneous byte_received & eop in RECEIVE: byte path taken first (byte stored); EOP
//   handled on a following shift_enable with bit_cnt==0.
// - d_edge ignored in START, CHK_SYNC, RECEIVE, STORE, NOMATCH (normal data edges).
// - r_error only rises on transitions marked above; only cleared by rst or a new packet start.
// TESTING
// - Good packet: edge, SYNC 8'h80, bytes A5,3C, EOP on byte boundary -> two w_enable pulses
//   with rx_data=A5 then 3C, rcving drops at EOP, r_error=0, ends in IDLE.
// - Bad sync: first byte 8'h81 then 1 byte, EOP -> no w_enable, r_error=1 from cycle after CHK_SYNC,
//   held through EIDLE; next packet start clears it.
// - Mid-byte EOP: SYNC, byte 11, then EOP after 3 bits -> one write (11), r_error=1, state EIDLE.
// - Overrun: rx_full=1 when byte 5A completes -> no w_enable, r_error=1, NOMATCH until EOP.
// - Reset mid-packet: rst=1 during RECEIVE with byte_received same cycle -> all outputs 0 next
//   cycle, no write, IDLE; following good packet received normally.
// - Coincidence: byte_received & eop same cycle -> byte stored, then clean EOP -> r_error=0.

Source files
------------

// File: rtl/rcv_control_fsm.sv
// USB receiver control unit: frames packets from the bit timer strobes, checks SYNC,
// and writes received data bytes into the RX FIFO with sticky error reporting.
module rcv_control_fsm #(
    parameter logic [7:0] SYNC_BYTE  = 8'h80,
    parameter int         BITS_PER_B = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    input  logic       rx_full,
    output logic       rcving,
    output logic       w_enable,
    output logic [7:0] rx_data,
    output logic       r_error
);

    localparam int CNT_W = $clog2(BITS_PER_B) + 1;

    typedef enum logic [3:0] {
        IDLE,
        START,
        CHK_SYNC,
        NOMATCH,
        RECEIVE,
        STORE,
        EOP_WAIT,
        EOP_WAIT_ERR,
        EIDLE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             next_error;
    logic             latch_byte;
    logic [CNT_W-1:0] bit_cnt;
    logic [7:0]       byte_q;

    always_comb begin
        next_state = state;
        next_error = r_error;
        latch_byte = 1'b0;
        case (state)
            IDLE: begin
                if (d_edge) begin
                    next_state = START;
                    next_error = 1'b0;
                end
            end
            START: begin
                if (byte_received) begin
                    next_state = CHK_SYNC;
                    latch_byte = 1'b1;
                end else if (eop) begin
                    next_state = EIDLE;
                    next_error = 1'b1;
                end
            end
            CHK_SYNC: begin
                if (byte_q == SYNC_BYTE) begin
                    next_state = RECEIVE;
                end else begin
                    next_state = NOMATCH;
                    next_error = 1'b1;
                end
            end
            NOMATCH: begin
                if (eop) next_state = EOP_WAIT_ERR;
            end
            RECEIVE: begin
                // A completed byte takes priority over an EOP seen in the same cycle.
                if (byte_received) begin
                    if (!rx_full) begin
                        next_state = STORE;
                        latch_byte = 1'b1;
                    end else begin
                        next_state = NOMATCH;
                        next_error = 1'b1;
                    end
                end else if (eop && shift_enable) begin
                    if (bit_cnt == '0) begin
                        next_state = EOP_WAIT;
                    end else begin
                        next_state = EOP_WAIT_ERR;
                        next_error = 1'b1;
                    end
                end
            end
            STORE:        next_state = RECEIVE;
            EOP_WAIT:     if (d_edge) next_state = IDLE;
            EOP_WAIT_ERR: if (d_edge) next_state = EIDLE;
            EIDLE: begin
                if (d_edge) begin
                    next_state = START;
                    next_error = 1'b0;
                end
            end
            default:      next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rcving   <= 1'b0;
            w_enable <= 1'b0;
            rx_data  <= 8'h00;
            r_error  <= 1'b0;
            bit_cnt  <= '0;
        end else begin
            state    <= next_state;
            rcving   <= next_state inside {START, CHK_SYNC, NOMATCH, RECEIVE, STORE};
            w_enable <= (state == STORE);
            r_error  <= next_error;
            if (state == STORE) rx_data <= byte_q;
            if (byte_received || state == IDLE || state == EIDLE)
                bit_cnt <= '0;
            else if (shift_enable && rcving)
                bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // Holding register for the byte under test; only meaningful once byte_received has fired.
    always_ff @(posedge clk) begin
        if (latch_byte) byte_q <= rcv_data;
    end

endmodule

// File: tb/tb_rcv_control_fsm.sv
// Bench for rcv_control_fsm: packet-level table and random packets against a behavioural model,
// plus cycle-level sequences for reset, write latency and byte/EOP coincidence.
module tb_rcv_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d_edge = 1'b0;
    logic       eop = 1'b0;
    logic       shift_enable = 1'b0;
    logic       byte_received = 1'b0;
    logic [7:0] rcv_data = 8'h00;
    logic       rx_full = 1'b0;
    logic       rcving;
    logic       w_enable;
    logic [7:0] rx_data;
    logic       r_error;

    rcv_control_fsm dut (
        .clk(clk),
        .rst(rst),
        .d_edge(d_edge),
        .eop(eop),
        .shift_enable(shift_enable),
        .byte_received(byte_received),
        .rcv_data(rcv_data),
        .rx_full(rx_full),
        .rcving(rcving),
        .w_enable(w_enable),
        .rx_data(rx_data),
        .r_error(r_error)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pk_bytes[$];
    bit         pk_full[$];
    logic       prev_we = 1'b0;

    // bytes: first byte in bits [7:0]; full: bit i set = FIFO full when byte i completes
    typedef struct {
        logic [7:0]  sync;
        int          nbytes;
        logic [23:0] bytes;
        logic [2:0]  full;
        int          eop_bits;
        int          exp_writes;
        logic        exp_err;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (w_enable) begin
            got_q.push_back(rx_data);
            check("w_enable single-cycle", 32'(prev_we), 32'd0);
        end
        prev_we = w_enable;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input bit se, input bit br, input bit de);
        shift_enable = se;
        byte_received = br;
        d_edge = de;
        cyc(1);
        shift_enable = 1'b0;
        byte_received = 1'b0;
        d_edge = 1'b0;
        cyc(2);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit full);
        rcv_data = b;
        rx_full = full;
        for (int i = 0; i < 7; i++) strobe(1'b1, 1'b0, 1'b0);
        strobe(1'b1, 1'b1, 1'b0);
        rx_full = 1'b0;
    endtask

    // Expected writes and error flag derived from the packet contents alone.
    function automatic logic model(input logic [7:0] sync, input int eop_bits);
        bit ovr = 0;
        exp_q.delete();
        if (sync == 8'h80) begin
            foreach (pk_bytes[i]) begin
                if (!ovr) begin
                    if (pk_full[i]) ovr = 1;
                    else exp_q.push_back(pk_bytes[i]);
                end
            end
        end
        return (sync != 8'h80) || ovr || (eop_bits != 0);
    endfunction

    task automatic run_packet(input logic [7:0] sync, input int eop_bits, input logic exp_err,
                              input string tag);
        logic [7:0] g;
        got_q.delete();
        strobe(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check({tag, " start rcving"}, 32'(rcving), 32'd1);
        check({tag, " start r_error"}, 32'(r_error), 32'd0);
        send_byte(sync, 1'b0);
        foreach (pk_bytes[i]) send_byte(pk_bytes[i], pk_full[i]);
        for (int k = 0; k < eop_bits; k++) strobe(1'b1, 1'b0, 1'b0);
        eop = 1'b1;
        strobe(1'b1, 1'b0, 1'b0);
        cyc(2);
        eop = 1'b0;
        strobe(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check({tag, " end rcving"}, 32'(rcving), 32'd0);
        check({tag, " end r_error"}, 32'(r_error), 32'(exp_err));
        check({tag, " write count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            check($sformatf("%s byte %0d", tag, i), 32'(g), 32'(exp_q[i]));
        end
    endtask

    task automatic load_table(input int t);
        pk_bytes.delete();
        pk_full.delete();
        exp_q.delete();
        for (int i = 0; i < tbl[t].nbytes; i++) begin
            pk_bytes.push_back(tbl[t].bytes[8*i +: 8]);
            pk_full.push_back(tbl[t].full[i]);
        end
        for (int i = 0; i < tbl[t].exp_writes; i++) exp_q.push_back(tbl[t].bytes[8*i +: 8]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got time limit, expected $finish");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        logic [7:0] s;
        int         eb;
        logic       e;

        tbl[0] = '{8'h80, 2, 24'h003CA5, 3'b000, 0, 2, 1'b0};
        tbl[1] = '{8'h81, 1, 24'h000077, 3'b000, 0, 0, 1'b1};
        tbl[2] = '{8'h80, 1, 24'h000011, 3'b000, 3, 1, 1'b1};
        tbl[3] = '{8'h80, 1, 24'h00005A, 3'b001, 0, 0, 1'b1};
        tbl[4] = '{8'h80, 3, 24'h030201, 3'b100, 0, 2, 1'b1};
        tbl[5] = '{8'h80, 0, 24'h000000, 3'b000, 0, 0, 1'b0};
        tbl[6] = '{8'h80, 2, 24'h0000FF, 3'b000, 7, 2, 1'b1};
        tbl[7] = '{8'h00, 2, 24'h008080, 3'b000, 0, 0, 1'b1};

        // Reset state
        cyc(3);
        @(negedge clk);
        check("reset rcving", 32'(rcving), 32'd0);
        check("reset w_enable", 32'(w_enable), 32'd0);
        check("reset rx_data", 32'(rx_data), 32'd0);
        check("reset r_error", 32'(r_error), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(2);

        for (int t = 0; t < 8; t++) begin
            load_table(t);
            run_packet(tbl[t].sync, tbl[t].eop_bits, tbl[t].exp_err, $sformatf("table%0d", t));
        end

        // Coincident byte_received and eop: byte stored 2 cycles later, then clean EOP
        got_q.delete();
        strobe(1'b0, 1'b0, 1'b1);
        send_byte(8'h80, 1'b0);
        rcv_data = 8'h6C;
        for (int i = 0; i < 7; i++) strobe(1'b1, 1'b0, 1'b0);
        eop = 1'b1;
        shift_enable = 1'b1;
        byte_received = 1'b1;
        @(posedge clk);
        #1 shift_enable = 1'b0;
        byte_received = 1'b0;
        @(negedge clk);
        check("coinc latency+1 w_enable", 32'(w_enable), 32'd0);
        @(negedge clk);
        check("coinc latency+2 w_enable", 32'(w_enable), 32'd1);
        check("coinc rx_data", 32'(rx_data), 32'h6C);
        @(negedge clk);
        check("coinc latency+3 w_enable", 32'(w_enable), 32'd0);
        check("coinc still rcving", 32'(rcving), 32'd1);
        strobe(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("coinc eop rcving", 32'(rcving), 32'd0);
        check("coinc eop r_error", 32'(r_error), 32'd0);
        eop = 1'b0;
        strobe(1'b0, 1'b0, 1'b1);
        check("coinc write count", 32'(got_q.size()), 32'd1);

        // Reset mid-packet, coincident with byte_received
        strobe(1'b0, 1'b0, 1'b1);
        send_byte(8'h80, 1'b0);
        rcv_data = 8'h44;
        for (int i = 0; i < 7; i++) strobe(1'b1, 1'b0, 1'b0);
        got_q.delete();
        shift_enable = 1'b1;
        byte_received = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1 shift_enable = 1'b0;
        byte_received = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("midrst rcving", 32'(rcving), 32'd0);
        check("midrst w_enable", 32'(w_enable), 32'd0);
        check("midrst rx_data", 32'(rx_data), 32'd0);
        check("midrst r_error", 32'(r_error), 32'd0);
        cyc(4);
        check("midrst no write", 32'(got_q.size()), 32'd0);
        load_table(0);
        run_packet(tbl[0].sync, tbl[0].eop_bits, tbl[0].exp_err, "after reset");

        // Random packets against the behavioural model
        for (int p = 0; p < 40; p++) begin
            s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h80;
            eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
            pk_bytes.delete();
            pk_full.delete();
            for (int i = 0; i < int'($urandom_range(0, 4)); i++) begin
                pk_bytes.push_back(8'($urandom));
                pk_full.push_back($urandom_range(0, 5) == 0);
            end
            e = model(s, eb);
            run_packet(s, eb, e, $sformatf("rand%0d", p));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
